// File: rtl/ddr_pkg.sv
// Shared widths and FSM encoding for the DDR write-side line packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr_pkg;

    localparam int LINE_W     = 128;
    localparam int WORD_W     = 16;
    localparam int LANES      = 8;
    localparam int LANE_SEL_W = 3;
    localparam int MASK_W     = 16;

    typedef enum logic [1:0] {
        WP_EMPTY,
        WP_FILL,
        WP_ISSUE
    } wp_state_e;

endpackage

// File: rtl/ddr_lane_merge.sv
// Merges one 16-bit halfword into a 128-bit line and clears its mask bits.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module ddr_lane_merge
    import ddr_pkg::*;
(
    input  logic [LINE_W-1:0]     line_i,
    input  logic [MASK_W-1:0]     mask_i,
    input  logic [LANE_SEL_W-1:0] lane_i,
    input  logic [WORD_W-1:0]     data_i,
    input  logic [1:0]            be_i,
    output logic [LINE_W-1:0]     line_o,
    output logic [MASK_W-1:0]     mask_o
);

    // Overwrite only the enabled bytes of the selected lane; mask 0 = byte written.
    always_comb begin
        line_o = line_i;
        mask_o = mask_i;
        for (int n = 0; n < LANES; n++) begin
            if (lane_i == LANE_SEL_W'(n)) begin
                if (be_i[0]) begin
                    line_o[WORD_W*n +: 8] = data_i[7:0];
                    mask_o[2*n]           = 1'b0;
                end
                if (be_i[1]) begin
                    line_o[WORD_W*n+8 +: 8] = data_i[15:8];
                    mask_o[2*n+1]           = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_write_pack.sv
// Packs halfword writes into one 128-bit DDR line with byte mask; optional idle timeout (DDR_WPACK_TIMEOUT_EN).
// Latency: write that fills the line -> ddr_req_valid on the next cycle; flush/miss -> ISSUE next cycle.
// Backpressure: wr_ready low in ISSUE and on a line miss in FILL; line held stable until ddr_req_ready.
module ddr_write_pack
    import ddr_pkg::*;
#(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WORD_W-1:0]   wr_data,
    input  logic [1:0]          wr_be,
    input  logic                flush,
    output logic                idle,
    output logic                ddr_req_valid,
    input  logic                ddr_req_ready,
    output logic [ADDR_W-4:0]   ddr_addr,
    output logic [LINE_W-1:0]   ddr_wdata,
    output logic [MASK_W-1:0]   ddr_wmask
);

    localparam int LA_W = ADDR_W - 3;

    wp_state_e          state_q, state_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [MASK_W-1:0]  mask_q, mask_d;
    logic [LA_W-1:0]    addr_q, addr_d;

    logic [LINE_W-1:0]  merged_line;
    logic [MASK_W-1:0]  merged_mask;
    logic               line_hit;
    logic               accept;
    logic               timeout_hit;

    // The buffer is all-zero / all-masked whenever EMPTY, so the same merge serves first and later writes.
    ddr_lane_merge u_merge (
        .line_i (line_q),
        .mask_i (mask_q),
        .lane_i (wr_addr[LANE_SEL_W-1:0]),
        .data_i (wr_data),
        .be_i   (wr_be),
        .line_o (merged_line),
        .mask_o (merged_mask)
    );

    assign line_hit = (wr_addr[ADDR_W-1:3] == addr_q);
    assign accept   = wr_valid && wr_ready;

`ifdef DDR_WPACK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Idle counter: runs only while sitting in FILL with no accepted write.
    always_comb begin
        cnt_d = '0;
        if (state_q == WP_FILL && state_d == WP_FILL && !accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, buffer update and write-side handshake.
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        wr_ready = 1'b0;
        case (state_q)
            WP_EMPTY: begin
                wr_ready = 1'b1;
                // A write with no byte enables is taken but leaves the buffer empty.
                if (wr_valid && (wr_be != 2'b00)) begin
                    addr_d  = wr_addr[ADDR_W-1:3];
                    line_d  = merged_line;
                    mask_d  = merged_mask;
                    state_d = WP_FILL;
                end
            end
            WP_FILL: begin
                wr_ready = line_hit;
                if (wr_valid && line_hit) begin
                    line_d = merged_line;
                    mask_d = merged_mask;
                end
                // A miss is stalled and replayed from EMPTY once this line has gone out.
                if (wr_valid && !line_hit) begin
                    state_d = WP_ISSUE;
                end else if ((mask_d == '0) || flush || (timeout_hit && !wr_valid)) begin
                    state_d = WP_ISSUE;
                end
            end
            WP_ISSUE: begin
                if (ddr_req_ready) begin
                    line_d  = '0;
                    mask_d  = '1;
                    state_d = WP_EMPTY;
                end
            end
            default: begin
                state_d = WP_EMPTY;
            end
        endcase
    end

    // State and line buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WP_EMPTY;
            line_q  <= '0;
            mask_q  <= '1;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
        end
    end

    assign idle          = (state_q == WP_EMPTY);
    assign ddr_req_valid = (state_q == WP_ISSUE);
    assign ddr_addr      = addr_q;
    assign ddr_wdata     = line_q;
    assign ddr_wmask     = mask_q;

endmodule

// File: tb/tb_ddr_write_pack.sv
// Directed bench for ddr_write_pack: table of single-write flush vectors plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: exercises ddr_req_ready stalls and line-miss stalls.
module tb_ddr_write_pack;
    import ddr_pkg::*;

    localparam int ADDR_W = 27;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data;
    logic [1:0]          wr_be;
    logic                flush;
    logic                idle;
    logic                ddr_req_valid;
    logic                ddr_req_ready;
    logic [ADDR_W-4:0]   ddr_addr;
    logic [LINE_W-1:0]   ddr_wdata;
    logic [MASK_W-1:0]   ddr_wmask;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic [1:0]        be;
        logic [ADDR_W-4:0] exp_addr;
        logic [15:0]       exp_mask;
        logic [127:0]      exp_wdata;
    } vec_t;

    vec_t vecs [5];

    ddr_write_pack #(.ADDR_W(ADDR_W), .TIMEOUT(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_be         (wr_be),
        .flush         (flush),
        .idle          (idle),
        .ddr_req_valid (ddr_req_valid),
        .ddr_req_ready (ddr_req_ready),
        .ddr_addr      (ddr_addr),
        .ddr_wdata     (ddr_wdata),
        .ddr_wmask     (ddr_wmask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Align to just after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one write from an aligned point; returns just after the accepting edge.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be);
        int n;
        n = 0;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        wr_valid = 1'b1;
        @(negedge clk);
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) chk("wr_accept_wait", wr_ready, 1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Called at a negedge with a request pending; ends aligned after the edge.
    task automatic handshake(input string name);
        ddr_req_ready = 1'b1;
        step();
        ddr_req_ready = 1'b0;
        @(negedge clk);
        chk({name, "_idle_after"}, idle, 1);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{27'h20,       16'hABCD, 2'b01, 24'h4,      16'hFFFE, 128'hCD};
        vecs[1] = '{27'h27,       16'h5A3C, 2'b10, 24'h4,      16'h7FFF, 128'h5A00_0000_0000_0000_0000_0000_0000_0000};
        vecs[2] = '{27'h03,       16'hBEEF, 2'b11, 24'h0,      16'hFF3F, 128'h0000_0000_0000_0000_BEEF_0000_0000_0000};
        vecs[3] = '{27'h7FF_FFFF, 16'h1234, 2'b01, 24'hFF_FFFF, 16'hBFFF, 128'h0034_0000_0000_0000_0000_0000_0000_0000};
        vecs[4] = '{27'h11,       16'hA5A5, 2'b11, 24'h2,      16'hFFF3, 128'h0000_0000_0000_0000_0000_0000_A5A5_0000};

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        flush = 1'b0; ddr_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_valid", ddr_req_valid, 0);
        chk("rst_addr", ddr_addr, 0);
        chk("rst_wdata", ddr_wdata, 0);
        chk("rst_wmask", ddr_wmask, 16'hFFFF);
        step();

        // Table: single write + flush
        foreach (vecs[i]) begin
            wr(vecs[i].addr, vecs[i].data, vecs[i].be);
            flush_pulse();
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), ddr_req_valid, 1);
            chk($sformatf("vec%0d_addr", i), ddr_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_mask", i), ddr_wmask, vecs[i].exp_mask);
            chk($sformatf("vec%0d_wdata", i), ddr_wdata, vecs[i].exp_wdata);
            handshake($sformatf("vec%0d", i));
        end

        // Full line 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            wr(27'h10 + 27'(i), 16'h1000 + 16'(i), 2'b11);
            if (i >= 6) begin
                @(negedge clk);
                chk($sformatf("full_valid_after_%0d", i), ddr_req_valid, (i == 7) ? 1 : 0);
                if (i == 6) step();
            end
        end
        chk("full_addr", ddr_addr, 24'h2);
        chk("full_mask", ddr_wmask, 16'h0000);
        for (int l = 0; l < 8; l++)
            chk($sformatf("full_lane%0d", l), ddr_wdata[16*l +: 16], 16'h1000 + 16'(l));
        handshake("full");

        // Flush in EMPTY is a no-op
        flush = 1'b1;
        repeat (3) @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("empty_flush_idle", idle, 1);
        chk("empty_flush_valid", ddr_req_valid, 0);
        step();

        // be=0 in EMPTY stays EMPTY
        wr(27'h50, 16'hFFFF, 2'b00);
        @(negedge clk);
        chk("be0_idle", idle, 1);
        chk("be0_mask", ddr_wmask, 16'hFFFF);
        step();

        // Miss: 0x30 then 0x48, with 10-cycle controller stall
        wr(27'h30, 16'h3333, 2'b11);
        wr_addr = 27'h48; wr_data = 16'h4848; wr_be = 2'b11; wr_valid = 1'b1;
        @(negedge clk);
        chk("miss_stall_ready", wr_ready, 0);
        step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), ddr_req_valid, 1);
            chk($sformatf("stall%0d_ready", k), wr_ready, 0);
            chk($sformatf("stall%0d_addr", k), ddr_addr, 24'h6);
            chk($sformatf("stall%0d_mask", k), ddr_wmask, 16'hFFFC);
            chk($sformatf("stall%0d_wdata", k), ddr_wdata, 128'h3333);
            step();
        end
        ddr_req_ready = 1'b1;
        step();
        ddr_req_ready = 1'b0;
        @(negedge clk);
        chk("miss_release_idle", idle, 1);
        chk("miss_release_wr_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("miss_replay_not_idle", idle, 0);
        step();
        flush_pulse();
        @(negedge clk);
        chk("miss_replay_addr", ddr_addr, 24'h9);
        chk("miss_replay_mask", ddr_wmask, 16'hFFFC);
        chk("miss_replay_wdata", ddr_wdata, 128'h4848);
        handshake("miss_replay");

        // Same-byte overwrite on lane 3
        wr(27'h63, 16'h1111, 2'b11);
        wr(27'h63, 16'h2200, 2'b10);
        flush_pulse();
        @(negedge clk);
        chk("ovw_addr", ddr_addr, 24'hC);
        chk("ovw_mask", ddr_wmask, 16'hFF3F);
        chk("ovw_lane3", ddr_wdata[63:48], 16'h2211);
        handshake("ovw");

        // Hit and flush in the same cycle
        wr(27'h70, 16'hAAAA, 2'b11);
        flush = 1'b1;
        wr(27'h71, 16'hBBBB, 2'b11);
        flush = 1'b0;
        @(negedge clk);
        chk("hitflush_valid", ddr_req_valid, 1);
        chk("hitflush_mask", ddr_wmask, 16'hFFF0);
        chk("hitflush_wdata", ddr_wdata, 128'hBBBB_AAAA);
        handshake("hitflush");

        // Idle timeout behaviour
        wr(27'h80, 16'h0808, 2'b11);
        n = 0;
        @(negedge clk);
        while (!ddr_req_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
`ifdef DDR_WPACK_TIMEOUT_EN
        chk("timeout_cycles", n, 64);
`else
        chk("no_timeout_valid", ddr_req_valid, 0);
        chk("no_timeout_cycles", n, 1000);
`endif
        step();
        flush_pulse();
        @(negedge clk);
        chk("timeout_line_valid", ddr_req_valid, 1);
        chk("timeout_line_addr", ddr_addr, 24'h10);
        handshake("timeout");

        // Reset while in ISSUE drops the line
        wr(27'h90, 16'h9999, 2'b11);
        flush_pulse();
        @(negedge clk);
        chk("rstissue_valid_before", ddr_req_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstissue_valid", ddr_req_valid, 0);
        chk("rstissue_idle", idle, 1);
        chk("rstissue_mask", ddr_wmask, 16'hFFFF);
        chk("rstissue_wdata", ddr_wdata, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
